// File: rtl/microroc_mode_switcher_if.sv
// Bundle of all routed signals around the Microroc mode switcher.
// master: command decoder / test engines / ASIC side that feeds and consumes the switcher.
// slave : the switcher itself.
interface microroc_mode_switcher_if #(
  parameter int DAC_NUM     = 3,
  parameter int DAC_WIDTH   = 10,
  parameter int DAC_SEL_W   = 2,
  parameter int CHANNEL_NUM = 64,
  parameter int DATA_WIDTH  = 16
);
  // requests and source-side configuration
  logic [1:0]                     ModeSelect;
  logic [DAC_SEL_W-1:0]           DacSelect;
  logic [DAC_NUM*DAC_WIDTH-1:0]   UsbDac;
  logic [DAC_WIDTH-1:0]           SCTestDac;
  logic [DAC_WIDTH-1:0]           SweepAcqDac;
  logic [3*CHANNEL_NUM-1:0]       UsbChannelMask;
  logic [3*CHANNEL_NUM-1:0]       SCTestChannelMask;
  logic [CHANNEL_NUM-1:0]         UsbCTestChannel;
  logic [CHANNEL_NUM-1:0]         SCTestCTestChannel;
  logic                           UsbSCParameterLoad;
  logic                           SCTestSCParameterLoad;
  logic                           SweepAcqSCParameterLoad;
  logic                           UsbSCOrReadreg;
  logic                           UsbAcqStartStop;
  logic                           SweepAcqAcqStartStop;
  logic                           UsbUsbStartStop;
  logic                           SweepTestUsbStartStop;
  logic [DATA_WIDTH-1:0]          MicrorocAcqData;
  logic [DATA_WIDTH-1:0]          SweepAcqData;
  logic [DATA_WIDTH-1:0]          SCTestData;
  logic                           MicrorocAcqData_en;
  logic                           SweepAcqData_en;
  logic                           SCTestData_en;
  // routed results
  logic [DAC_NUM*DAC_WIDTH-1:0]   OutDac;
  logic [3*CHANNEL_NUM-1:0]       OutChannelMask;
  logic [CHANNEL_NUM-1:0]         OutCTestChannel;
  logic                           OutSCParameterLoad;
  logic                           OutSCOrReadreg;
  logic                           OutUsbStartStop;
  logic                           MicrorocAcqStartStop;
  logic [DATA_WIDTH-1:0]          UsbFifoData;
  logic                           UsbFifoData_en;
  logic [DATA_WIDTH-1:0]          ParallelData;
  logic                           ParallelData_en;
  logic [1:0]                     ActiveMode;
  logic                           SwitchBusy;
  logic                           DrainTimeout;

  modport master (
    output ModeSelect, DacSelect, UsbDac, SCTestDac, SweepAcqDac,
           UsbChannelMask, SCTestChannelMask, UsbCTestChannel, SCTestCTestChannel,
           UsbSCParameterLoad, SCTestSCParameterLoad, SweepAcqSCParameterLoad,
           UsbSCOrReadreg, UsbAcqStartStop, SweepAcqAcqStartStop,
           UsbUsbStartStop, SweepTestUsbStartStop,
           MicrorocAcqData, SweepAcqData, SCTestData,
           MicrorocAcqData_en, SweepAcqData_en, SCTestData_en,
    input  OutDac, OutChannelMask, OutCTestChannel, OutSCParameterLoad,
           OutSCOrReadreg, OutUsbStartStop, MicrorocAcqStartStop,
           UsbFifoData, UsbFifoData_en, ParallelData, ParallelData_en,
           ActiveMode, SwitchBusy, DrainTimeout
  );

  modport slave (
    input  ModeSelect, DacSelect, UsbDac, SCTestDac, SweepAcqDac,
           UsbChannelMask, SCTestChannelMask, UsbCTestChannel, SCTestCTestChannel,
           UsbSCParameterLoad, SCTestSCParameterLoad, SweepAcqSCParameterLoad,
           UsbSCOrReadreg, UsbAcqStartStop, SweepAcqAcqStartStop,
           UsbUsbStartStop, SweepTestUsbStartStop,
           MicrorocAcqData, SweepAcqData, SCTestData,
           MicrorocAcqData_en, SweepAcqData_en, SCTestData_en,
    output OutDac, OutChannelMask, OutCTestChannel, OutSCParameterLoad,
           OutSCOrReadreg, OutUsbStartStop, MicrorocAcqStartStop,
           UsbFifoData, UsbFifoData_en, ParallelData, ParallelData_en,
           ActiveMode, SwitchBusy, DrainTimeout
  );
endinterface

// File: rtl/microroc_mode_switcher.sv
// Registered Microroc mode switcher. Routes SC configuration, strobes and
// readout data from USB/ACQ, S-curve test or sweep-ACQ. A mode change drains
// the old source (strobes forced low, data still flowing), swaps the config,
// holds it for a settle window and only then re-enables strobes.
module microroc_mode_switcher #(
  parameter int DAC_NUM       = 3,
  parameter int DAC_WIDTH     = 10,
  parameter int DAC_SEL_W     = 2,
  parameter int CHANNEL_NUM   = 64,
  parameter int DATA_WIDTH    = 16,
  parameter int GUARD_CYCLES  = 16,
  parameter int DRAIN_TIMEOUT = 1024,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic Clk,
  input  logic reset,
  microroc_mode_switcher_if.slave bus
);

  localparam logic [1:0] MODE_ACQ    = 2'b00;
  localparam logic [1:0] MODE_SCURVE = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;

  localparam int IDLE_W   = $clog2(GUARD_CYCLES + 1);
  localparam int DRAIN_W  = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SETTLE} state_t;

  // FSM state
  state_t                r_state;
  logic [1:0]            r_active;
  logic [1:0]            r_target;
  logic [IDLE_W-1:0]     r_idle;
  logic [DRAIN_W-1:0]    r_drain;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_timeout;
  logic                  r_busy;

  // registered outputs
  logic [DAC_NUM*DAC_WIDTH-1:0] r_out_dac;
  logic [3*CHANNEL_NUM-1:0]     r_out_mask;
  logic [CHANNEL_NUM-1:0]       r_out_ctest;
  logic                         r_out_load;
  logic                         r_out_scor;
  logic                         r_out_usbss;
  logic                         r_out_acqss;
  logic [DATA_WIDTH-1:0]        r_fifo_d;
  logic                         r_fifo_en;
  logic [DATA_WIDTH-1:0]        r_par_d;
  logic                         r_par_en;

  // next-state values
  state_t                w_state_nxt;
  logic [1:0]            w_active_nxt;
  logic [1:0]            w_target_nxt;
  logic [IDLE_W-1:0]     w_idle_nxt;
  logic [DRAIN_W-1:0]    w_drain_nxt;
  logic [SETTLE_W-1:0]   w_settle_nxt;
  logic                  w_timeout_nxt;
  logic                  w_old_en;

  // routed (pre-register) values
  logic [DAC_SEL_W-1:0]         w_dacsel;
  logic [DAC_NUM*DAC_WIDTH-1:0] w_dac;
  logic [3*CHANNEL_NUM-1:0]     w_mask;
  logic [CHANNEL_NUM-1:0]       w_ctest;
  logic                         w_load;
  logic                         w_scor;
  logic                         w_usbss;
  logic                         w_acqss;
  logic [DATA_WIDTH-1:0]        w_fifo_d;
  logic                         w_fifo_en;
  logic                         w_par_en;

  assign w_dacsel = bus.DacSelect;

  // Data strobes of the mode currently applied; a drain waits for these to go quiet.
  always_comb begin
    w_old_en = 1'b0;
    case (r_active)
      MODE_ACQ:    w_old_en = bus.MicrorocAcqData_en;
      MODE_SCURVE: w_old_en = bus.SCTestData_en;
      MODE_SWEEP:  w_old_en = bus.SweepAcqData_en | bus.MicrorocAcqData_en;
      default:     w_old_en = 1'b0;
    endcase
  end

  // Next-state logic: switch request, drain with idle guard / timeout, settle.
  always_comb begin
    w_state_nxt   = r_state;
    w_active_nxt  = r_active;
    w_target_nxt  = r_target;
    w_idle_nxt    = r_idle;
    w_drain_nxt   = r_drain;
    w_settle_nxt  = r_settle;
    w_timeout_nxt = r_timeout;
    case (r_state)
      ST_RUN: begin
        if (bus.ModeSelect != r_active) begin
          w_target_nxt = bus.ModeSelect;
          w_idle_nxt   = '0;
          w_drain_nxt  = '0;
          w_state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_drain_nxt = r_drain + DRAIN_W'(1);
        w_idle_nxt  = w_old_en ? '0 : r_idle + IDLE_W'(1);
        // the idle guard wins if it completes on the last allowed drain cycle
        if (!w_old_en && (r_idle == IDLE_W'(GUARD_CYCLES - 1))) begin
          w_active_nxt = r_target;
          w_settle_nxt = '0;
          w_state_nxt  = ST_SETTLE;
        end else if (r_drain == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
          w_timeout_nxt = 1'b1;
          w_active_nxt  = r_target;
          w_settle_nxt  = '0;
          w_state_nxt   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle == SETTLE_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_RUN;
        else                                         w_settle_nxt = r_settle + SETTLE_W'(1);
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Routing by the mode being applied next cycle, then gating by the next state,
  // so strobes drop on the very edge that starts a drain.
  always_comb begin
    w_dac     = bus.UsbDac;
    w_mask    = bus.UsbChannelMask;
    w_ctest   = bus.UsbCTestChannel;
    w_load    = 1'b0;
    w_scor    = 1'b0;
    w_usbss   = 1'b0;
    w_acqss   = 1'b0;
    w_fifo_d  = bus.MicrorocAcqData;
    w_fifo_en = 1'b0;
    w_par_en  = 1'b0;
    case (w_active_nxt)
      MODE_ACQ: begin
        w_load    = bus.UsbSCParameterLoad;
        w_scor    = bus.UsbSCOrReadreg;
        w_usbss   = bus.UsbUsbStartStop;
        w_acqss   = bus.UsbAcqStartStop;
        w_fifo_en = bus.MicrorocAcqData_en;
      end
      MODE_SCURVE: begin
        w_dac     = {DAC_NUM{bus.SCTestDac}};
        w_mask    = bus.SCTestChannelMask;
        w_ctest   = bus.SCTestCTestChannel;
        w_load    = bus.SCTestSCParameterLoad;
        w_usbss   = bus.SweepTestUsbStartStop;
        w_fifo_d  = bus.SCTestData;
        w_fifo_en = bus.SCTestData_en;
      end
      MODE_SWEEP: begin
        // DacSelect k overrides DAC k-1; 0 or out-of-range leaves USB codes
        for (int k = 0; k < DAC_NUM; k++) begin
          if (int'(w_dacsel) == k + 1) w_dac[k*DAC_WIDTH +: DAC_WIDTH] = bus.SweepAcqDac;
        end
        w_load    = bus.SweepAcqSCParameterLoad;
        w_usbss   = bus.SweepTestUsbStartStop;
        w_acqss   = bus.SweepAcqAcqStartStop;
        w_fifo_d  = bus.SweepAcqData;
        w_fifo_en = bus.SweepAcqData_en;
        w_par_en  = bus.MicrorocAcqData_en;
      end
      default: begin
        // NONE: config from USB, every strobe quiet
        w_scor = bus.UsbSCOrReadreg;
      end
    endcase
    if (w_state_nxt != ST_RUN) begin
      w_load  = 1'b0;
      w_usbss = 1'b0;
      w_acqss = 1'b0;
    end
    if (w_state_nxt == ST_SETTLE) begin
      w_fifo_en = 1'b0;
      w_par_en  = 1'b0;
    end
  end

  // Single register stage for FSM and every output; reset abandons any switch.
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_active    <= MODE_ACQ;
      r_target    <= MODE_ACQ;
      r_idle      <= '0;
      r_drain     <= '0;
      r_settle    <= '0;
      r_timeout   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_dac   <= '0;
      r_out_mask  <= '0;
      r_out_ctest <= '0;
      r_out_load  <= 1'b0;
      r_out_scor  <= 1'b0;
      r_out_usbss <= 1'b0;
      r_out_acqss <= 1'b0;
      r_fifo_d    <= '0;
      r_fifo_en   <= 1'b0;
      r_par_d     <= '0;
      r_par_en    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_active    <= w_active_nxt;
      r_target    <= w_target_nxt;
      r_idle      <= w_idle_nxt;
      r_drain     <= w_drain_nxt;
      r_settle    <= w_settle_nxt;
      r_timeout   <= w_timeout_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
      // the old configuration stays frozen on the ASIC while draining
      if (w_state_nxt != ST_DRAIN) begin
        r_out_dac   <= w_dac;
        r_out_mask  <= w_mask;
        r_out_ctest <= w_ctest;
      end
      r_out_load  <= w_load;
      r_out_scor  <= w_scor;
      r_out_usbss <= w_usbss;
      r_out_acqss <= w_acqss;
      r_fifo_d    <= w_fifo_d;
      r_fifo_en   <= w_fifo_en;
      r_par_d     <= bus.MicrorocAcqData;
      r_par_en    <= w_par_en;
    end
  end

  assign bus.OutDac               = r_out_dac;
  assign bus.OutChannelMask       = r_out_mask;
  assign bus.OutCTestChannel      = r_out_ctest;
  assign bus.OutSCParameterLoad   = r_out_load;
  assign bus.OutSCOrReadreg       = r_out_scor;
  assign bus.OutUsbStartStop      = r_out_usbss;
  assign bus.MicrorocAcqStartStop = r_out_acqss;
  assign bus.UsbFifoData          = r_fifo_d;
  assign bus.UsbFifoData_en       = r_fifo_en;
  assign bus.ParallelData         = r_par_d;
  assign bus.ParallelData_en      = r_par_en;
  assign bus.ActiveMode           = r_active;
  assign bus.SwitchBusy           = r_busy;
  assign bus.DrainTimeout         = r_timeout;

endmodule

// File: tb/tb_microroc_mode_switcher.sv
// Bench for microroc_mode_switcher: directed vectors, USB FIFO words checked
// through an expected-word queue drained by an independent monitor.
module tb_microroc_mode_switcher;
  localparam int DN = 3, DW = 10, DSW = 2, CN = 64, DTW = 16;

  logic Clk = 1'b0;
  logic reset;
  always #5 Clk = ~Clk;

  microroc_mode_switcher_if #(.DAC_NUM(DN), .DAC_WIDTH(DW), .DAC_SEL_W(DSW),
    .CHANNEL_NUM(CN), .DATA_WIDTH(DTW)) bus();

  microroc_mode_switcher #(.DAC_NUM(DN), .DAC_WIDTH(DW), .DAC_SEL_W(DSW),
    .CHANNEL_NUM(CN), .DATA_WIDTH(DTW), .GUARD_CYCLES(16), .DRAIN_TIMEOUT(1024),
    .SETTLE_CYCLES(8)) dut (.Clk(Clk), .reset(reset), .bus(bus));

  int total = 0;
  int bad   = 0;
  logic [DTW-1:0] exp_q[$];
  logic           stream_on  = 1'b0;
  logic [DTW-1:0] stream_val = '0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int v, input int lo, input int hi);
    total++;
    if (v < lo || v > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // waits for SwitchBusy to fall, returns busy cycles seen; expiry is a failure
  task automatic wait_idle(input string name, input int limit, output int n);
    n = 0;
    while (bus.SwitchBusy === 1'b1 && n < limit) begin
      n++;
      tick();
    end
    if (n >= limit) chk({name, "_bound"}, bus.SwitchBusy, 1'b0);
  endtask

  // Monitor: every USB FIFO write must match the next expected word,
  // or the stream value while a permanently-enabled source is running.
  always @(negedge Clk) begin
    if (reset === 1'b0 && bus.UsbFifoData_en === 1'b1) begin
      if (exp_q.size() > 0)  chk("fifo_word", bus.UsbFifoData, exp_q.pop_front());
      else if (stream_on)    chk("fifo_stream", bus.UsbFifoData, stream_val);
      else                   chk("fifo_unexpected", bus.UsbFifoData_en, 1'b0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.ModeSelect = 2'b00; bus.DacSelect = '0;
    bus.UsbDac = {10'h300, 10'h200, 10'h100};
    bus.SCTestDac = 10'h2AA; bus.SweepAcqDac = 10'h155;
    bus.UsbChannelMask = {3{64'h0123_4567_89AB_CDEF}};
    bus.SCTestChannelMask = {3{64'hFEDC_BA98_7654_3210}};
    bus.UsbCTestChannel = 64'h0000_0000_0000_00F0;
    bus.SCTestCTestChannel = 64'h8000_0000_0000_0001;
    bus.UsbSCParameterLoad = 0; bus.SCTestSCParameterLoad = 0; bus.SweepAcqSCParameterLoad = 0;
    bus.UsbSCOrReadreg = 1; bus.UsbAcqStartStop = 0; bus.SweepAcqAcqStartStop = 0;
    bus.UsbUsbStartStop = 0; bus.SweepTestUsbStartStop = 0;
    bus.MicrorocAcqData = '0; bus.SweepAcqData = '0; bus.SCTestData = '0;
    bus.MicrorocAcqData_en = 0; bus.SweepAcqData_en = 0; bus.SCTestData_en = 0;
    reset = 1'b1;
    repeat (3) tick();

    // reset state
    chk("rst_outputs", {bus.OutDac, bus.OutChannelMask, bus.OutCTestChannel,
        bus.OutSCParameterLoad, bus.OutSCOrReadreg, bus.OutUsbStartStop,
        bus.MicrorocAcqStartStop, bus.UsbFifoData, bus.UsbFifoData_en,
        bus.ParallelData, bus.ParallelData_en}, '0);
    chk("rst_mode", {bus.ActiveMode, bus.SwitchBusy, bus.DrainTimeout}, '0);
    reset = 1'b0;

    // ACQ pass-through with 1-cycle latency
    bus.MicrorocAcqData = 16'h1234; bus.MicrorocAcqData_en = 1; exp_q.push_back(16'h1234);
    bus.UsbAcqStartStop = 1; bus.UsbUsbStartStop = 1;
    tick();
    bus.MicrorocAcqData_en = 0;
    chk("acq_mode", bus.ActiveMode, 2'b00);
    chk("acq_acqss", bus.MicrorocAcqStartStop, 1'b1);
    chk("acq_usbss", bus.OutUsbStartStop, 1'b1);
    chk("acq_scor", bus.OutSCOrReadreg, 1'b1);
    chk("acq_dac", bus.OutDac, {10'h300, 10'h200, 10'h100});
    chk("acq_par_en", bus.ParallelData_en, 1'b0);

    // ACQ -> SCURVE with 5 words in flight
    bus.ModeSelect = 2'b01;
    bus.MicrorocAcqData = 16'hA000; bus.MicrorocAcqData_en = 1; exp_q.push_back(16'hA000);
    tick();
    chk("drain_acqss_forced", bus.MicrorocAcqStartStop, 1'b0);
    chk("drain_busy", bus.SwitchBusy, 1'b1);
    chk("drain_cfg_held", bus.OutDac, {10'h300, 10'h200, 10'h100});
    n = 0;
    for (int i = 1; i < 5; i++) begin
      if (bus.SwitchBusy === 1'b1) n++;
      bus.MicrorocAcqData = 16'hA000 + 16'(i); exp_q.push_back(16'hA000 + 16'(i));
      tick();
    end
    bus.MicrorocAcqData_en = 0; bus.UsbAcqStartStop = 0;
    begin
      int m;
      wait_idle("sw_scurve", 200, m);
      n += m;
    end
    chk_rng("sw_scurve_busy_len", n, 28, 30);
    chk("sc_mode", bus.ActiveMode, 2'b01);
    chk("sc_dac", bus.OutDac, {3{10'h2AA}});
    chk("sc_mask", bus.OutChannelMask, {3{64'hFEDC_BA98_7654_3210}});
    chk("sc_ctest", bus.OutCTestChannel, 64'h8000_0000_0000_0001);
    chk("sc_scor", bus.OutSCOrReadreg, 1'b0);
    bus.UsbAcqStartStop = 1; bus.SweepTestUsbStartStop = 1;
    bus.SCTestData = 16'h5C5C; bus.SCTestData_en = 1; exp_q.push_back(16'h5C5C);
    bus.MicrorocAcqData = 16'hDEAD; bus.MicrorocAcqData_en = 1;
    tick();
    bus.SCTestData_en = 0; bus.MicrorocAcqData_en = 0;
    chk("sc_acqss_zero", bus.MicrorocAcqStartStop, 1'b0);
    chk("sc_usbss", bus.OutUsbStartStop, 1'b1);

    // SCURVE -> SWEEP while SCTest data never stops: drain times out
    bus.SCTestData = 16'hBEEF; bus.SCTestData_en = 1;
    stream_val = 16'hBEEF; stream_on = 1'b1;
    bus.ModeSelect = 2'b10;
    tick();
    wait_idle("sw_timeout", 1200, n);
    chk_rng("timeout_busy_len", n, 1032, 1033);
    chk("timeout_flag", bus.DrainTimeout, 1'b1);
    chk("timeout_mode", bus.ActiveMode, 2'b10);
    bus.SCTestData_en = 0;
    tick(); tick();
    stream_on = 1'b0;

    // SWEEP_ACQ DAC override and data paths
    bus.DacSelect = 2;
    tick();
    chk("sw_dac_sel2", bus.OutDac, {10'h300, 10'h155, 10'h100});
    chk("sw_acqss_zero", bus.MicrorocAcqStartStop, 1'b0);
    chk("sw_mask_usb", bus.OutChannelMask, {3{64'h0123_4567_89AB_CDEF}});
    bus.DacSelect = 0;
    tick();
    chk("sw_dac_sel0", bus.OutDac, {10'h300, 10'h200, 10'h100});
    bus.DacSelect = 3;
    tick();
    chk("sw_dac_sel3", bus.OutDac, {10'h155, 10'h200, 10'h100});
    bus.SweepAcqData = 16'h5A5A; bus.SweepAcqData_en = 1; exp_q.push_back(16'h5A5A);
    bus.MicrorocAcqData = 16'h0077; bus.MicrorocAcqData_en = 1;
    bus.SweepAcqAcqStartStop = 1;
    tick();
    bus.SweepAcqData_en = 0; bus.MicrorocAcqData_en = 0; bus.SweepAcqAcqStartStop = 0;
    chk("sw_par_data", bus.ParallelData, 16'h0077);
    chk("sw_par_en", bus.ParallelData_en, 1'b1);
    chk("sw_acqss", bus.MicrorocAcqStartStop, 1'b1);

    // back to ACQ; sticky timeout flag survives
    bus.ModeSelect = 2'b00;
    tick();
    wait_idle("sw_acq", 200, n);
    chk_rng("acq_busy_len", n, 24, 25);
    chk("acq2_mode", bus.ActiveMode, 2'b00);
    chk("timeout_sticky", bus.DrainTimeout, 1'b1);

    // ModeSelect 01 then 10 mid-drain
    bus.ModeSelect = 2'b01;
    tick();
    repeat (3) tick();
    bus.ModeSelect = 2'b10;
    wait_idle("mid_first", 200, n);
    chk("mid_first_mode", bus.ActiveMode, 2'b01);
    tick();
    chk("mid_second_busy", bus.SwitchBusy, 1'b1);
    wait_idle("mid_second", 200, n);
    chk("mid_second_mode", bus.ActiveMode, 2'b10);

    // NONE: everything quiet, SCOrReadreg from USB
    bus.ModeSelect = 2'b11;
    tick();
    wait_idle("sw_none", 200, n);
    chk("none_mode", bus.ActiveMode, 2'b11);
    bus.MicrorocAcqData = 16'h9999; bus.MicrorocAcqData_en = 1;
    tick();
    bus.MicrorocAcqData_en = 0;
    chk("none_fifo_en", bus.UsbFifoData_en, 1'b0);
    chk("none_acqss", bus.MicrorocAcqStartStop, 1'b0);
    chk("none_scor", bus.OutSCOrReadreg, 1'b1);

    // leave NONE: trivial drain, then reset in SETTLE
    bus.ModeSelect = 2'b00;
    tick();
    n = 0;
    while (bus.SwitchBusy === 1'b1 && bus.ActiveMode === 2'b11 && n < 100) begin
      n++;
      tick();
    end
    chk("none_drain_len", n, 16);
    chk("settle_busy", bus.SwitchBusy, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    chk("rst2_outputs", {bus.OutDac, bus.OutChannelMask, bus.OutCTestChannel,
        bus.OutSCParameterLoad, bus.OutSCOrReadreg, bus.OutUsbStartStop,
        bus.MicrorocAcqStartStop, bus.UsbFifoData, bus.UsbFifoData_en,
        bus.ParallelData, bus.ParallelData_en}, '0);
    chk("rst2_mode", {bus.ActiveMode, bus.SwitchBusy, bus.DrainTimeout}, '0);
    reset = 1'b0;
    tick();
    chk("post_rst_idle", {bus.ActiveMode, bus.SwitchBusy}, '0);

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/microroc_mode_switcher.md
Name: microroc_mode_switcher

Overview:
- Parametrised, registered successor to the combinational Microroc mode mux.
- Routes slow-control parameters (DACs, channel masks, CTest channel), SC load, start/stop strobes and readout data among three sources: USB/ACQ, S-curve test and sweep-ACQ.
- Mode changes are handshaked. The block forces strobes low, drains in-flight data from the old source, applies the new configuration and lets it settle before enabling the new source.
- Sits between the USB command decoder / test engines and the Microroc SC and readout logic.

Parameters:
- DAC_NUM, 3, number of 10-bit-class DACs routed.
- DAC_WIDTH, 10, width of each DAC code.
- DAC_SEL_W, 2, width of DacSelect.
- CHANNEL_NUM, 64, ASIC channels. Mask width is 3*CHANNEL_NUM.
- DATA_WIDTH, 16, readout data width.
- GUARD_CYCLES, 16, consecutive idle-enable cycles needed to finish draining.
- DRAIN_TIMEOUT, 1024, maximum number of DRAIN cycles.
- SETTLE_CYCLES, 8, cycles the new configuration is held before strobes are enabled.

Ports:
- Clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ModeSelect  in  2  requested mode: 00 ACQ, 01 SCURVE, 10 SWEEP_ACQ, 11 NONE
- DacSelect  in  DAC_SEL_W  SWEEP_ACQ DAC override: 0 none; k selects DAC k-1
- UsbDac  in  DAC_NUM*DAC_WIDTH  USB DAC codes, DAC0 in LSBs
- SCTestDac, SweepAcqDac  in  DAC_WIDTH  test-engine DAC codes
- UsbChannelMask, SCTestChannelMask  in  3*CHANNEL_NUM  discriminator masks
- UsbCTestChannel, SCTestCTestChannel  in  CHANNEL_NUM  CTest enables
- UsbSCParameterLoad, SCTestSCParameterLoad, SweepAcqSCParameterLoad  in  1  SC load pulses
- UsbSCOrReadreg  in  1  SC/read-register select
- UsbAcqStartStop, SweepAcqAcqStartStop  in  1  acquisition start/stop
- UsbUsbStartStop, SweepTestUsbStartStop  in  1  USB transfer start/stop
- MicrorocAcqData, SweepAcqData, SCTestData  in  DATA_WIDTH  source data
- MicrorocAcqData_en, SweepAcqData_en, SCTestData_en  in  1  source data strobes
- OutDac  out  DAC_NUM*DAC_WIDTH  routed DAC codes
- OutChannelMask  out  3*CHANNEL_NUM  routed channel mask
- OutCTestChannel  out  CHANNEL_NUM  routed CTest enables
- OutSCParameterLoad, OutSCOrReadreg, OutUsbStartStop, MicrorocAcqStartStop  out  1  routed control
- UsbFifoData  out  DATA_WIDTH; UsbFifoData_en  out  1  USB FIFO write path
- ParallelData  out  DATA_WIDTH; ParallelData_en  out  1  side-channel ACQ data
- ActiveMode  out  2  mode currently applied
- SwitchBusy  out  1  high during DRAIN and SETTLE
- DrainTimeout  out  1  sticky; set when a drain timed out

Behaviour:
- Every output is registered, with 1-cycle latency from inputs to outputs in RUN.
- Reset values:
  - All outputs 0, ActiveMode = 00, state RUN, counters 0, DrainTimeout 0.
  - From the first cycle after reset, ACQ routing applies.
  - Reset mid-switch abandons the switch immediately.
- Routing per ActiveMode:
  - ACQ: all USB sources; UsbFifo <- MicrorocAcqData; Parallel en = 0.
  - SCURVE: every DAC <- SCTestDac; masks and CTest from SCTest; load <- SCTest load; SCOrReadreg = 0; UsbStartStop <- SweepTest; AcqStartStop = 0; UsbFifo <- SCTestData.
  - SWEEP_ACQ: DAC k-1 <- SweepAcqDac when DacSelect == k and 1 <= k <= DAC_NUM, otherwise the USB code. Masks and CTest from USB; load <- SweepAcq load; SCOrReadreg = 0; UsbStartStop <- SweepTest; AcqStartStop <- SweepAcq; UsbFifo <- SweepAcqData; Parallel <- MicrorocAcqData.
  - NONE: configuration from USB; SCOrReadreg from USB; all strobes, loads and data enables 0.
- Data buses are registered unconditionally; only the _en outputs are gated.
- A DacSelect change inside SWEEP_ACQ in RUN applies next cycle with no drain.
- FSM:
  - RUN: if ModeSelect != ActiveMode, latch Target <- ModeSelect and go to DRAIN.
  - DRAIN:
    - Forced to 0: OutSCParameterLoad, OutUsbStartStop, MicrorocAcqStartStop.
    - Config outputs are held.
    - Data paths stay routed from the old mode, so in-flight words pass.
    - IdleCnt increments while the old mode's routed enables are all 0 and clears to 0 when any is 1.
    - At IdleCnt == GUARD_CYCLES: ActiveMode <- Target, go to SETTLE.
    - At DrainCnt == DRAIN_TIMEOUT-1: set DrainTimeout, ActiveMode <- Target, go to SETTLE.
  - SETTLE:
    - Config outputs follow the new mode.
    - Strobes, loads and all data _en outputs are forced 0.
    - After SETTLE_CYCLES cycles, go to RUN.
- ModeSelect changes during DRAIN or SETTLE are ignored. The comparison is re-evaluated on the first RUN cycle, which may start another switch at once.
- A switch to the same mode cannot occur.
- Leaving NONE drains trivially: enables are 0, so the drain takes GUARD_CYCLES cycles.
- DrainTimeout clears only on reset.

Test Plan:
- Reset, then drive MicrorocAcqData = 0x1234 with en = 1 -> one cycle later UsbFifoData = 0x1234, UsbFifoData_en = 1, ActiveMode = 00.
- In ACQ, hold UsbAcqStartStop = 1 and MicrorocAcqData_en = 1 for 5 cycles, then drop it; switch ModeSelect to 01 -> MicrorocAcqStartStop = 0 the cycle after the switch request. All 5 words appear. SwitchBusy stays high for (5 + 16 + 8) ± 1 cycles. ActiveMode = 01 afterwards; OutDac = 3 copies of SCTestDac.
- SWEEP_ACQ with DacSelect = 2, SweepAcqDac = 0x155, UsbDac = {0x300, 0x200, 0x100} -> OutDac = {0x300, 0x155, 0x100}. With DacSelect = 0 -> USB codes.
- Switch with SCTestData_en held at 1 permanently -> after 1024 DRAIN cycles DrainTimeout = 1 and ActiveMode updates. The flag persists across later switches until reset.
- Change ModeSelect 00 -> 01 -> 10 mid-DRAIN -> first switch completes to 01, then a second switch to 10 starts on the first RUN cycle.
- Assert reset during SETTLE -> next cycle all outputs 0, ActiveMode = 00, SwitchBusy = 0.
